// File: rtl/accum_pkg.sv
// Shared constants and types for the accum_32 accumulator slice.
//   DATA_W  : operand / result width
//   state_e : FSM state encoding (IDLE, ACC, DONE)
package accum_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage : accum_pkg

// File: rtl/accum_if.sv
// Handshake bundle between an accumulator and its producer/consumer.
//   start/len         : run request and operand count (producer -> accumulator)
//   in_valid/in_data  : operand stream, in_ready back-pressure
//   out_valid/out_sum/out_ovf : result, out_ready from the consumer
//   busy              : accumulator not idle
// slave  = accumulator side, master = producer/consumer side.
interface accum_if #(
    parameter int CNT_W = 8
) ();
    import accum_pkg::*;

    logic              start;
    logic [CNT_W-1:0]  len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_sum;
    logic              out_ovf;
    logic              out_ready;
    logic              busy;

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, busy
    );

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, busy
    );

endinterface : accum_if

// File: rtl/csa_32.sv
// 32-bit carry-select adder: the low half ripples, the high half is
// computed for both carry-in values and selected by the low-half carry.
//   a, b : operands
//   cin  : carry in
//   sum  : a + b + cin modulo 2^32
//   cout : carry out of bit 31
module csa_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [16:0] lo_s;
    logic [16:0] hi0_s;
    logic [16:0] hi1_s;

    // Both high-half candidates are formed in parallel with the low half.
    always_comb begin
        lo_s  = {1'b0, a[15:0]}  + {1'b0, b[15:0]}  + {16'd0, cin};
        hi0_s = {1'b0, a[31:16]} + {1'b0, b[31:16]};
        hi1_s = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;
        if (lo_s[16]) begin
            sum  = {hi1_s[15:0], lo_s[15:0]};
            cout = hi1_s[16];
        end else begin
            sum  = {hi0_s[15:0], lo_s[15:0]};
            cout = hi0_s[16];
        end
    end

endmodule : csa_32

// File: rtl/accum_32.sv
// Run-length accumulator: after start, sums len unsigned 32-bit operands
// and presents the sum plus a sticky carry-out flag until the consumer
// takes it.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : accum_if slave (start/len, operand stream, result, busy)
module accum_32
    import accum_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic    clk,
    input  logic    rst,
    accum_if.slave  bus
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    logic [DATA_W-1:0] sum_s;
    logic              cout_s;

    csa_32 u_csa (
        .a    (acc_q),
        .b    (bus.in_data),
        .cin  (1'b0),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // Next-state and datapath update for the IDLE/ACC/DONE controller.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d = {DATA_W{1'b0}};
                    ovf_d = 1'b0;
                    if (bus.len != {CNT_W{1'b0}}) begin
                        rem_d   = bus.len;
                        state_d = ST_ACC;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                // in_ready is high throughout ACC, so in_valid alone accepts.
                if (bus.in_valid) begin
                    acc_d = sum_s;
                    ovf_d = ovf_q | cout_s;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and decoded-output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= {DATA_W{1'b0}};
            ovf_q       <= 1'b0;
            rem_q       <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            rem_q       <= rem_d;
            in_ready_q  <= (state_d == ST_ACC);
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    // acc/ovf are only touched by start and accepted operands, so they
    // double as the held result after DONE returns to IDLE.
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.out_sum   = acc_q;
    assign bus.out_ovf   = ovf_q;

endmodule : accum_32

// File: tb/tb_accum_32.sv
module tb_accum_32;

    typedef struct packed {
        logic [31:0] sum;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    logic        mon_seen = 1'b0;
    logic [31:0] mon_sum  = 32'd0;
    logic        mon_ovf  = 1'b0;

    accum_if #(.CNT_W(8)) bus ();

    accum_32 #(.CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, " in_ready"},  {31'd0, bus.in_ready},  32'd0);
        chk({tag, " busy"},      {31'd0, bus.busy},      32'd0);
        chk({tag, " out_sum"},   bus.out_sum,            32'd0);
        chk({tag, " out_ovf"},   {31'd0, bus.out_ovf},   32'd0);
    endtask

    task automatic start_run(input logic [7:0] n);
        bus.start = 1'b1;
        bus.len   = n;
        tick();
        bus.start = 1'b0;
        chk("busy after start", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic send(input logic [31:0] d);
        chk("in_ready before accept", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("out_valid after take", {31'd0, bus.out_valid}, 32'd0);
        chk("busy after take",      {31'd0, bus.busy},      32'd0);
    endtask

    // Monitor: pops the expected result when out_valid rises, then
    // checks the result holds for as long as out_valid stays high.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (!mon_seen) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected out_valid: got sum 0x%08h with no result pending", bus.out_sum);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_sum", bus.out_sum, e.sum);
                        chk("out_ovf", {31'd0, bus.out_ovf}, {31'd0, e.ovf});
                    end
                    mon_sum  = bus.out_sum;
                    mon_ovf  = bus.out_ovf;
                    mon_seen = 1'b1;
                end else begin
                    chk("out_sum hold", bus.out_sum, mon_sum);
                    chk("out_ovf hold", {31'd0, bus.out_ovf}, {31'd0, mon_ovf});
                end
            end else begin
                mon_seen = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start     = 1'b0;
        bus.len       = 8'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.out_ready = 1'b0;

        // Reset state, during and after rst.
        rst = 1'b1;
        tick();
        tick();
        chk_zero("in reset");
        rst = 1'b0;
        tick();
        chk_zero("after reset");

        // len=3: 1+2+3, result one cycle after the third acceptance.
        exp_q.push_back('{sum: 32'd6, ovf: 1'b0});
        start_run(8'd3);
        send(32'd1);
        send(32'd2);
        chk("out_valid before last", {31'd0, bus.out_valid}, 32'd0);
        send(32'd3);
        chk("out_valid latency len3", {31'd0, bus.out_valid}, 32'd1);
        consume();

        // len=2 with wrap: 0xFFFFFFFF + 2 = 1, carry out.
        exp_q.push_back('{sum: 32'h0000_0001, ovf: 1'b1});
        start_run(8'd2);
        send(32'hFFFF_FFFF);
        send(32'h0000_0002);
        chk("out_valid latency len2", {31'd0, bus.out_valid}, 32'd1);
        consume();
        chk("out_sum kept in IDLE", bus.out_sum, 32'h0000_0001);
        chk("out_ovf kept in IDLE", {31'd0, bus.out_ovf}, 32'd1);

        // len=0: straight to DONE with cleared result.
        exp_q.push_back('{sum: 32'd0, ovf: 1'b0});
        start_run(8'd0);
        chk("len0 out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("len0 in_ready",  {31'd0, bus.in_ready},  32'd0);
        consume();

        // len=4 with 3-cycle input stalls and a 5-cycle output stall.
        exp_q.push_back('{sum: 32'd100, ovf: 1'b0});
        start_run(8'd4);
        for (int i = 0; i < 4; i++) begin
            send(32'd10 * (i + 1));
            if (i < 3) begin
                bus.in_data = 32'hDEAD_BEEF;
                repeat (3) begin
                    tick();
                    chk("stall in_ready",  {31'd0, bus.in_ready},  32'd1);
                    chk("stall out_valid", {31'd0, bus.out_valid}, 32'd0);
                end
            end
        end
        chk("out_valid len4", {31'd0, bus.out_valid}, 32'd1);
        repeat (5) begin
            tick();
            chk("out_valid held", {31'd0, bus.out_valid}, 32'd1);
        end
        consume();

        // len=5 aborted by reset after two acceptances, then a fresh run.
        start_run(8'd5);
        send(32'd7);
        send(32'd8);
        rst = 1'b1;
        tick();
        chk_zero("mid-run reset");
        rst = 1'b0;
        tick();
        chk_zero("after mid-run reset");
        repeat (4) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'h0000_0055;
            tick();
            bus.in_valid = 1'b0;
            chk("no result after abort", {31'd0, bus.out_valid}, 32'd0);
        end
        exp_q.push_back('{sum: 32'h0000_0010, ovf: 1'b0});
        start_run(8'd1);
        send(32'h0000_0010);
        chk("out_valid len1", {31'd0, bus.out_valid}, 32'd1);
        consume();

        // len=255 of 0x01000000 with start pulses during ACC and DONE.
        exp_q.push_back('{sum: 32'hFF00_0000, ovf: 1'b0});
        start_run(8'hFF);
        for (int i = 0; i < 255; i++) begin
            if ((i % 64) == 5) begin
                bus.start = 1'b1;
                bus.len   = 8'd1;
            end
            send(32'h0100_0000);
            bus.start = 1'b0;
            if (i == 253) begin
                chk("out_valid before 255th", {31'd0, bus.out_valid}, 32'd0);
            end
        end
        chk("out_valid len255", {31'd0, bus.out_valid}, 32'd1);
        bus.start = 1'b1;
        bus.len   = 8'd3;
        tick();
        bus.start = 1'b0;
        chk("start ignored in DONE", {31'd0, bus.out_valid}, 32'd1);
        consume();

        tick();
        tick();
        chk("results outstanding", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_accum_32
